// File: rtl/maxim_pipe.sv
// maxim_pipe: pipelined NCH-channel maximum finder with channel index and peak-hold tracking.
// Comparator tree is heap-ordered: node n has children 2n and 2n+1; leaves are the input channels.
module maxim_pipe #(
    parameter int WIDTH  = 4,
    parameter int NCH    = 4,
    parameter int SIGNED = 0,
    parameter int CNTW   = 8,
    localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LAT   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic                 peak_clr,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_max,
    output logic [IDXW-1:0]      out_idx,
    output logic                 peak_valid,
    output logic [WIDTH-1:0]     peak_max,
    output logic [IDXW-1:0]      peak_idx,
    output logic [CNTW-1:0]      peak_cnt,
    output logic [CNTW-1:0]      peak_at
);
    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    logic [WIDTH-1:0] nv [1:NCH-1];
    logic [IDXW-1:0]  ni [1:NCH-1];
    logic [LAT-1:0]   vr;
    logic [LAT:0]     vs;

    assign vs = {vr, in_valid};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vr <= '0;
        else vr <= vs[LAT-1:0];

    for (genvar n = 1; n < NCH; n++) begin : g_node
        localparam int D = $clog2(n + 1) - 1;
        logic [WIDTH-1:0] a, b;
        logic [IDXW-1:0]  ia, ib;
        if (2 * n >= NCH) begin : g_leaf
            assign a  = in_data[(2*n-NCH)*WIDTH +: WIDTH];
            assign b  = in_data[(2*n+1-NCH)*WIDTH +: WIDTH];
            assign ia = IDXW'(2*n-NCH);
            assign ib = IDXW'(2*n+1-NCH);
        end else begin : g_int
            assign a  = nv[2*n];
            assign b  = nv[2*n+1];
            assign ia = ni[2*n];
            assign ib = ni[2*n+1];
        end
        // the right child must win strictly, so ties keep the lower channel
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                nv[n] <= '0;
                ni[n] <= '0;
            end else if (vs[LAT-1-D]) begin
                nv[n] <= gt(b, a) ? b : a;
                ni[n] <= gt(b, a) ? ib : ia;
            end
    end

    assign out_valid = vr[LAT-1];
    assign out_max   = nv[1];
    assign out_idx   = ni[1];

    logic [CNTW-1:0] cnt_inc;
    logic            take;

    assign cnt_inc = (&peak_cnt) ? peak_cnt : peak_cnt + 1'b1;
    assign take    = out_valid && (!peak_valid || gt(out_max, peak_max));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            peak_valid <= 1'b0;
            peak_max   <= '0;
            peak_idx   <= '0;
            peak_cnt   <= '0;
            peak_at    <= '0;
        end else if (peak_clr) begin
            peak_valid <= out_valid;
            peak_max   <= out_valid ? out_max : '0;
            peak_idx   <= out_valid ? out_idx : '0;
            peak_cnt   <= CNTW'(out_valid);
            peak_at    <= '0;
        end else if (take) begin
            peak_valid <= 1'b1;
            peak_max   <= out_max;
            peak_idx   <= out_idx;
            peak_at    <= peak_cnt;
            peak_cnt   <= cnt_inc;
        end else if (out_valid) begin
            peak_cnt   <= cnt_inc;
        end
endmodule

// File: tb/tb_maxim_pipe.sv
// tb_maxim_pipe: scoreboard bench for maxim_pipe in unsigned, signed and 16-channel configurations.
module tb_maxim_pipe;
    logic clk = 0, rst_n = 1;
    always #5 clk = ~clk;

    int compared = 0, failed = 0;

    typedef struct {
        logic [7:0] m;
        logic [3:0] i;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];
    exp_t last0;

    logic iv0 = 0, clr0 = 0, ov0, pv0;
    logic [15:0] d0 = 0;
    logic [3:0] om0, pm0;
    logic [1:0] oi0, pi0;
    logic [7:0] pc0, pa0;

    logic iv1 = 0, clr1 = 0, ov1, pv1;
    logic [15:0] d1 = 0;
    logic [3:0] om1, pm1;
    logic [1:0] oi1, pi1;
    logic [7:0] pc1, pa1;

    logic iv2 = 0, clr2 = 0, ov2, pv2;
    logic [127:0] d2 = 0;
    logic [7:0] om2, pm2;
    logic [3:0] oi2, pi2, pc2, pa2;

    maxim_pipe #(.WIDTH(4), .NCH(4), .SIGNED(0), .CNTW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(d0), .peak_clr(clr0),
        .out_valid(ov0), .out_max(om0), .out_idx(oi0), .peak_valid(pv0),
        .peak_max(pm0), .peak_idx(pi0), .peak_cnt(pc0), .peak_at(pa0));

    maxim_pipe #(.WIDTH(4), .NCH(4), .SIGNED(1), .CNTW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(d1), .peak_clr(clr1),
        .out_valid(ov1), .out_max(om1), .out_idx(oi1), .peak_valid(pv1),
        .peak_max(pm1), .peak_idx(pi1), .peak_cnt(pc1), .peak_at(pa1));

    maxim_pipe #(.WIDTH(8), .NCH(16), .SIGNED(0), .CNTW(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_data(d2), .peak_clr(clr2),
        .out_valid(ov2), .out_max(om2), .out_idx(oi2), .peak_valid(pv2),
        .peak_max(pm2), .peak_idx(pi2), .peak_cnt(pc2), .peak_at(pa2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", n, a, e);
        end
    endtask

    task automatic unexpected(input string n);
        compared++;
        failed++;
        $display("FAIL %s: out_valid with empty scoreboard (got 1, required 0)", n);
    endtask

    // expected out_valid of u0: in_valid delayed two cycles, discarded by reset
    logic [1:0] h0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) h0 <= 2'b00;
        else h0 <= {h0[0], iv0};

    always @(negedge clk) begin
        if (!rst_n) begin
            last0.m = 0;
            last0.i = 0;
        end else begin
            chk("u0 out_valid timing", 32'(ov0), 32'(h0[1]));
            if (ov0) begin
                if (q0.size() == 0) unexpected("u0");
                else begin
                    last0 = q0.pop_front();
                    chk("u0 out_max", 32'(om0), 32'(last0.m));
                    chk("u0 out_idx", 32'(oi0), 32'(last0.i));
                end
            end else begin
                chk("u0 hold max", 32'(om0), 32'(last0.m));
                chk("u0 hold idx", 32'(oi0), 32'(last0.i));
            end
        end
    end

    always @(negedge clk)
        if (rst_n && ov1) begin
            if (q1.size() == 0) unexpected("u1");
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1 out_max", 32'(om1), 32'(e.m));
                chk("u1 out_idx", 32'(oi1), 32'(e.i));
            end
        end

    always @(negedge clk)
        if (rst_n && ov2) begin
            if (q2.size() == 0) unexpected("u2");
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("u2 out_max", 32'(om2), 32'(e.m));
                chk("u2 out_idx", 32'(oi2), 32'(e.i));
            end
        end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic s0(input logic [3:0] a, b, c, d, em, input logic [1:0] ei);
        exp_t e;
        e.m = 8'(em);
        e.i = 4'(ei);
        d0 = {d, c, b, a};
        iv0 = 1;
        q0.push_back(e);
        cyc();
        iv0 = 0;
    endtask

    task automatic s1(input logic [3:0] a, b, c, d, em, input logic [1:0] ei);
        exp_t e;
        e.m = 8'(em);
        e.i = 4'(ei);
        d1 = {d, c, b, a};
        iv1 = 1;
        q1.push_back(e);
        cyc();
        iv1 = 0;
    endtask

    task automatic peak0(input string n, input logic v, input logic [3:0] m,
                         input logic [1:0] i, input logic [7:0] c, input logic [7:0] at);
        chk({n, " peak_valid"}, 32'(pv0), 32'(v));
        chk({n, " peak_max"}, 32'(pm0), 32'(m));
        chk({n, " peak_idx"}, 32'(pi0), 32'(i));
        chk({n, " peak_cnt"}, 32'(pc0), 32'(c));
        chk({n, " peak_at"}, 32'(pa0), 32'(at));
    endtask

    initial begin
        exp_t e;
        logic [7:0] w, m, pmx;
        logic [3:0] ix, pix;
        int pcnt, pat;
        logic pvm;
        #1 rst_n = 0;
        #2;
        chk("reset out_valid", 32'(ov0), 0);
        chk("reset out_max", 32'(om0), 0);
        chk("reset out_idx", 32'(oi0), 0);
        peak0("reset", 0, 0, 0, 0, 0);
        chk("reset u2 out_valid", 32'(ov2), 0);
        cyc(2);
        rst_n = 1;
        cyc();

        s0(4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 2'd1);
        s0(4'd10, 4'd5, 4'd2, 4'd14, 4'd14, 2'd3);
        s0(4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 2'd0);
        cyc(3);
        peak0("burst", 1, 14, 3, 3, 1);

        s0(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 2'd0);
        s0(4'd14, 4'd0, 4'd0, 4'd0, 4'd14, 2'd0);
        cyc(3);
        peak0("equal", 1, 14, 3, 5, 1);

        s0(4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 2'd3);
        d0 = 16'hFFFF;
        cyc();
        s0(4'd8, 4'd7, 4'd8, 4'd1, 4'd8, 2'd0);
        d0 = 16'hFFFF;
        cyc();
        s0(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        d0 = 16'hFFFF;
        cyc();
        s0(4'd15, 4'd15, 4'd0, 4'd1, 4'd15, 2'd0);
        d0 = 16'hFFFF;
        cyc(4);
        peak0("bubbles", 1, 15, 0, 9, 8);

        s0(4'd6, 4'd0, 4'd0, 4'd0, 4'd6, 2'd0);
        cyc();
        clr0 = 1;
        cyc();
        clr0 = 0;
        cyc();
        peak0("clr+valid", 1, 6, 0, 1, 0);
        clr0 = 1;
        cyc();
        clr0 = 0;
        peak0("clr alone", 0, 0, 0, 0, 0);

        s1(4'h8, 4'hF, 4'hD, 4'hE, 4'hF, 2'd1);
        s1(4'h7, 4'h0, 4'h0, 4'h0, 4'h7, 2'd0);
        cyc(3);
        chk("u1 peak_max", 32'(pm1), 7);
        chk("u1 peak_idx", 32'(pi1), 0);
        chk("u1 peak_at", 32'(pa1), 1);
        chk("u1 peak_cnt", 32'(pc1), 2);

        pcnt = 0;
        pat = 0;
        pvm = 0;
        pmx = 0;
        pix = 0;
        for (int k = 0; k < 20; k++) begin
            m = 0;
            ix = 0;
            for (int i = 0; i < 16; i++) begin
                w = (k % 3 == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
                d2[i*8 +: 8] = w;
                if (i == 0 || w > m) begin
                    m = w;
                    ix = 4'(i);
                end
            end
            if (!pvm || m > pmx) begin
                pvm = 1;
                pmx = m;
                pix = ix;
                pat = pcnt;
            end
            if (pcnt < 15) pcnt++;
            e.m = m;
            e.i = ix;
            q2.push_back(e);
            iv2 = 1;
            cyc();
        end
        iv2 = 0;
        cyc(7);
        chk("u2 peak_valid", 32'(pv2), 1);
        chk("u2 peak_max", 32'(pm2), 32'(pmx));
        chk("u2 peak_idx", 32'(pi2), 32'(pix));
        chk("u2 peak_at", 32'(pa2), 32'(pat));
        chk("u2 peak_cnt saturated", 32'(pc2), 32'(pcnt));

        s0(4'd3, 4'd0, 4'd0, 4'd0, 4'd3, 2'd0);
        cyc(3);
        d0 = 16'h0009;
        iv0 = 1;
        cyc();
        d0 = 16'h00A0;
        cyc();
        iv0 = 0;
        rst_n = 0;
        #1;
        q0.delete();
        chk("async reset out_valid", 32'(ov0), 0);
        chk("async reset out_max", 32'(om0), 0);
        chk("async reset out_idx", 32'(oi0), 0);
        peak0("async reset", 0, 0, 0, 0, 0);
        cyc(2);
        rst_n = 1;
        cyc(6);
        chk("post reset peak_valid", 32'(pv0), 0);

        chk("u0 scoreboard drained", q0.size(), 0);
        chk("u1 scoreboard drained", q1.size(), 0);
        chk("u2 scoreboard drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/maxim_pipe.md
Name: maxim_pipe

Overview:
- Parametrised, pipelined N-channel maximum finder. It is the clocked successor of the 4-input 4-bit combinational maximizer.
- Each valid input sample is a vector of NCH words. The block returns the largest word and its channel index after a fixed latency.
- A peak-hold register tracks the largest value seen since the last clear, with the sample index at which it occurred.
- Sits between sample sources and downstream threshold/display logic.

Parameters:
- WIDTH, 4: bits per channel word, 2..16.
- NCH, 4: number of channels; power of two, 2..16.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.
- CNTW, 8: width of the peak sample counter.
- Derived IDXW = log2(NCH), minimum 1.
- Derived LAT = log2(NCH), i.e. pipeline depth.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- peak_clr  in  1  synchronous clear of the peak-hold state.
- out_valid  out  1  out_max/out_idx valid this cycle.
- out_max  out  WIDTH  maximum word of the sample.
- out_idx  out  IDXW  channel index of out_max.
- peak_valid  out  1  peak_max holds a value.
- peak_max  out  WIDTH  largest out_max since the last clear.
- peak_idx  out  IDXW  channel of peak_max.
- peak_cnt  out  CNTW  samples retired since the last clear; saturates.
- peak_at  out  CNTW  value of peak_cnt at the sample that set peak_max.

Behaviour:
- Reset (rst_n=0, asynchronous): every output and every pipeline register goes to 0. In-flight samples are discarded; nothing appears after reset deasserts.
- Pipeline: binary comparator tree with one register stage per level.
  - Stage k compares pairs from stage k-1 and registers the winning value and index.
  - A valid bit shifts alongside the data.
  - out_valid = in_valid delayed exactly LAT cycles.
  - Throughput: one sample per cycle, no backpressure.
  - When in_valid=0, data registers may hold stale values but valid bits are 0.
- Compare rules:
  - SIGNED=0: unsigned magnitude.
  - SIGNED=1: WIDTH-bit two's complement.
  - Ties: the lower channel index wins at every tree node, so out_idx is the lowest index holding the maximum.
- Output registers hold their last values while out_valid=0.
- Peak-hold, evaluated each cycle in priority order:
  1. peak_clr=1 and out_valid=1: load the current result, set peak_valid=1, peak_cnt=1, peak_at=0.
  2. peak_clr=1 and out_valid=0: peak_valid=0, peak_max=0, peak_idx=0, peak_cnt=0, peak_at=0.
  3. out_valid=1 and peak_valid=0: load the result, peak_valid=1, peak_at=peak_cnt, peak_cnt+1.
  4. out_valid=1 and result strictly greater than peak_max (same signedness rule): load the result, peak_at=peak_cnt, peak_cnt+1. On equality the earlier peak is kept.
  5. Otherwise, if out_valid=1: peak_cnt+1.
- peak_cnt saturates at 2^CNTW-1 and never wraps. peak_at keeps counting positions only while the counter is not saturated.
- Peak outputs are registered and change one cycle after the out_valid that affects them.
- peak_clr does not disturb the pipeline; samples in flight are retired normally after the clear.

Test Plan:
- WIDTH=4, NCH=4, SIGNED=0. Back-to-back samples {A,B,C,D} = {0,3,0,0}, then {10,5,2,14}, then {5,5,5,5}.
  - out_valid pulses on cycles 2, 3 and 4 after the first in_valid.
  - Results in order: (3,idx1), (14,idx3), (5,idx0).
  - Final peak_max=14, peak_idx=3, peak_at=1, peak_cnt=3.
- Same configuration with SIGNED=1. Input {8,F,D,E} (i.e. -8,-1,-3,-2) -> out_max=4'hF, out_idx=1. Input {7,0,0,0} -> 7, idx0.
- Ties and bubbles: {9,9,9,9} -> idx0. Alternate in_valid 1/0 for 8 cycles -> out_valid reproduces the pattern delayed 2 cycles. Equal later value leaves peak_at unchanged.
- Assert peak_clr on the same cycle out_valid carries value 6 -> peak_max=6, peak_cnt=1, peak_at=0. Assert peak_clr alone -> peak_valid=0 and all peak outputs 0.
- Pull rst_n low with 2 samples in flight -> all outputs 0 immediately (asynchronously); no out_valid after release.
- NCH=16, WIDTH=8, CNTW=4, random samples checked against a reference model. Feed 20 samples -> peak_cnt sticks at 15.
